// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired-zero x0, busy scoreboard and post-reset clear sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   ra_addr,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] ra_data,
  output logic [XLEN-1:0] rb_data,
  output logic            ra_busy,
  output logic            rb_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic            ready
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] mem_q [NREG];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            wr_ok, iss_ok;

  logic [AW-1:0]   rd_addr [2];
  logic [XLEN-1:0] rd_data [2];
  logic            rd_busy [2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= AW'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_RUN);
    wr_ok     = ready && wr_en && (wr_addr != '0);
    iss_ok    = ready && iss_en && (iss_addr != '0);
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == S_CLEAR) begin
      mem_we = 1'b1;
    end else if (wr_ok) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Issue is applied after writeback so a simultaneous new producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr]  = 1'b0;
    if (iss_ok) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic byp;
`ifdef REGFILE_BYPASS_EN
    assign byp = wr_ok && (wr_addr == rd_addr[gi]);
`else
    assign byp = 1'b0;
`endif
    always_comb begin
      rd_data[gi] = '0;
      rd_busy[gi] = 1'b0;
      if (ready && (rd_addr[gi] != '0)) begin
        if (byp) begin
          rd_data[gi] = wr_data;
          rd_busy[gi] = iss_ok && (iss_addr == rd_addr[gi]);
        end else begin
          rd_data[gi] = mem_q[rd_addr[gi]];
          rd_busy[gi] = busy_q[rd_addr[gi]];
        end
      end
    end
  end

  assign ra_data = rd_data[0];
  assign rb_data = rd_data[1];
  assign ra_busy = rd_busy[0];
  assign rb_busy = rd_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reference model compared every cycle plus directed literal checks.
// Define REGFILE_BYPASS_EN for both bench and RTL to test the bypass build.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [AW-1:0]   ra_addr, rb_addr, wr_addr, iss_addr;
  logic [XLEN-1:0] ra_data, rb_data, wr_data;
  logic            ra_busy, rb_busy, wr_en, iss_en, ready;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .reset_n(reset_n),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .ra_busy(ra_busy), .rb_busy(rb_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep is a countdown; on completion every register is simply zero.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  int              m_clear_left;
  bit              m_run   = 1'b0;
  bit              m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid      = 1'b1;
      m_run        = 1'b0;
      m_clear_left = NREG - 1;
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (m_valid && !m_run) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        m_run = 1'b1;
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      end
    end else if (m_run) begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  end

  function automatic logic [XLEN:0] model_read(input logic [AW-1:0] a);
    if (!m_run || a == 0) return '0;
    if (BYP && wr_en && wr_addr == a) return {(iss_en && iss_addr == a), wr_data};
    return {m_busy[a], m_mem[a]};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      logic [XLEN:0] ea, eb;
      ea = model_read(ra_addr);
      eb = model_read(rb_addr);
      chk("model_ready",   {63'd0, ready},   {63'd0, m_run});
      chk("model_ra_data", {32'd0, ra_data}, {32'd0, ea[XLEN-1:0]});
      chk("model_rb_data", {32'd0, rb_data}, {32'd0, eb[XLEN-1:0]});
      chk("model_ra_busy", {63'd0, ra_busy}, {63'd0, ea[XLEN]});
      chk("model_rb_busy", {63'd0, rb_busy}, {63'd0, eb[XLEN]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input bit we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                    input bit ie, input logic [AW-1:0] ia);
    wr_en = we; wr_addr = wa; wr_data = wd; iss_en = ie; iss_addr = ia;
    $display("txn %s: wr_en=%0b wr_addr=%0d wr_data=%h iss_en=%0b iss_addr=%0d", tag, we, wa, wd, ie, ia);
    step();
    wr_en = 1'b0; iss_en = 1'b0;
  endtask

  // Counts cycles with ready low after reset release; junk strobes are dropped early in the sweep.
  task automatic run_sweep(output int low);
    low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) break;
      low++;
      if (i == 10) begin
        @(posedge clk); #1;
        wr_en = 1'b0; iss_en = 1'b0;
      end
    end
    step();
  endtask

  initial begin
    int low;
    reset_n = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
    wr_addr = '0; wr_data = '0; iss_addr = '0; ra_addr = '0; rb_addr = '0;
    step(); step();
    chk("reset_ready", {63'd0, ready}, 64'd0);

    // Sweep with write/issue strobes that must be ignored.
    reset_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; iss_en = 1'b1; iss_addr = 5'd4;
    ra_addr = 5'd3; rb_addr = 5'd4;
    run_sweep(low);
    $display("txn sweep: ready low for %0d cycles", low);
    chk("sweep_len", 64'(low), 64'd31);
    for (int i = 1; i < NREG; i++) begin
      ra_addr = AW'(i); rb_addr = AW'(NREG - i);
      @(negedge clk);
      chk("sweep_zero_a", {32'd0, ra_data}, 64'd0);
      chk("sweep_zero_b", {32'd0, rb_data}, 64'd0);
      chk("sweep_busy_a", {63'd0, ra_busy}, 64'd0);
      step();
    end

    // x0 is hardwired.
    ra_addr = 5'd0; rb_addr = 5'd0;
    op("x0_write", 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0);
    @(negedge clk);
    chk("x0_data", {32'd0, ra_data}, 64'd0);
    chk("x0_busy", {63'd0, ra_busy}, 64'd0);
    step();

    // Scoreboard on x5.
    ra_addr = 5'd5;
    op("iss_x5", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    @(negedge clk);
    chk("x5_busy_after_iss", {63'd0, ra_busy}, 64'd1);
    step();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
    $display("txn wb_x5: wr_data=00001234");
    @(negedge clk);
    chk("x5_data_wcycle", {32'd0, ra_data}, BYP ? 64'h1234 : 64'h0);
    chk("x5_busy_wcycle", {63'd0, ra_busy}, BYP ? 64'd0 : 64'd1);
    step();
    wr_en = 1'b0;
    @(negedge clk);
    chk("x5_data_after", {32'd0, ra_data}, 64'h1234);
    chk("x5_busy_after",  {63'd0, ra_busy}, 64'd0);
    step();

    // Same-cycle issue and writeback on x7; then busy-on-busy and one clearing writeback.
    ra_addr = 5'd7; rb_addr = 5'd7;
    op("iss_wb_x7", 1'b1, 5'd7, 32'hAA, 1'b1, 5'd7);
    @(negedge clk);
    chk("x7_busy", {63'd0, ra_busy}, 64'd1);
    chk("x7_data", {32'd0, ra_data}, 64'hAA);
    step();
    op("iss_x7_again", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    op("wb_x7", 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0);
    @(negedge clk);
    chk("x7_busy_cleared", {63'd0, rb_busy}, 64'd0);
    step();

    // Dual-port read of x9.
    op("wb_x9", 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    ra_addr = 5'd9; rb_addr = 5'd9;
    @(negedge clk);
    chk("x9_port_a", {32'd0, ra_data}, 64'h99);
    chk("x9_port_b", {32'd0, rb_data}, 64'h99);
    step();

    // Mixed traffic, checked by the model alone.
    for (int i = 0; i < 150; i++) begin
      wr_en = 1'($urandom); wr_addr = AW'($urandom_range(0, NREG - 1)); wr_data = $urandom;
      iss_en = 1'($urandom); iss_addr = AW'($urandom_range(0, NREG - 1));
      ra_addr = AW'($urandom_range(0, NREG - 1)); rb_addr = AW'($urandom_range(0, NREG - 1));
      step();
    end
    wr_en = 1'b0; iss_en = 1'b0;
    $display("txn mixed traffic: 150 cycles");

    // Reset mid-sweep at cnt = 10.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    repeat (9) step();
    reset_n = 1'b0; step(); reset_n = 1'b1;
    run_sweep(low);
    $display("txn mid-sweep reset: ready low for %0d cycles", low);
    chk("midsweep_len", 64'(low), 64'd31);

    // Reset during RUN with busy bits set.
    op("iss_x2", 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
    op("iss_x3", 1'b1, 5'd3, 32'h33, 1'b1, 5'd3);
    ra_addr = 5'd2; rb_addr = 5'd3;
    @(negedge clk);
    chk("run_busy_x2", {63'd0, ra_busy}, 64'd1);
    step();
    reset_n = 1'b0; step(); reset_n = 1'b1;
    run_sweep(low);
    $display("txn run reset: ready low for %0d cycles", low);
    chk("runreset_len", 64'(low), 64'd31);
    @(negedge clk);
    chk("runreset_busy_x2", {63'd0, ra_busy}, 64'd0);
    chk("runreset_data_x3", {32'd0, rb_data}, 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
